// File: rtl/id_ex_ctrl_pipe.sv
// Registered decode/control stage: decodes the ID instruction into the control bundle, holds it
// in the ID/EX register, and generates load-use stalls, flush bubbles and a stall counter.
module id_ex_ctrl_pipe #(
  parameter int EN_M      = 0,
  parameter int EN_HAZARD = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      instr_i,
  input  logic             id_valid_i,
  input  logic             flush_i,
  input  logic             ex_memread_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memwrite_o,
  output logic             ex_memread_o,
  output logic             ex_alusrc_o,
  output logic [5:0]       ex_extop_o,
  output logic [4:0]       ex_aluop_o,
  output logic [4:0]       ex_npcop_o,
  output logic [1:0]       ex_wdsel_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       ex_rs1_o,
  output logic [4:0]       ex_rs2_o,
  output logic             ex_illegal_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [5:0] EXT_SH = 6'b100000;
  localparam logic [5:0] EXT_I  = 6'b010000;
  localparam logic [5:0] EXT_S  = 6'b001000;
  localparam logic [5:0] EXT_B  = 6'b000100;
  localparam logic [5:0] EXT_U  = 6'b000010;
  localparam logic [5:0] EXT_J  = 6'b000001;

  localparam logic [4:0] ALU_LUI  = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_BNE  = 5'b00101;
  localparam logic [4:0] ALU_BLT  = 5'b00110;
  localparam logic [4:0] ALU_BGE  = 5'b00111;
  localparam logic [4:0] ALU_BLTU = 5'b01000;
  localparam logic [4:0] ALU_BGEU = 5'b01001;
  localparam logic [4:0] ALU_SLT  = 5'b01010;
  localparam logic [4:0] ALU_SLTU = 5'b01011;
  localparam logic [4:0] ALU_XOR  = 5'b01100;
  localparam logic [4:0] ALU_OR   = 5'b01101;
  localparam logic [4:0] ALU_AND  = 5'b01110;
  localparam logic [4:0] ALU_SLL  = 5'b01111;
  localparam logic [4:0] ALU_SRL  = 5'b10000;
  localparam logic [4:0] ALU_SRA  = 5'b10001;
  localparam logic [4:0] ALU_MUL  = 5'b10010;

  localparam logic [4:0] NPC_BR   = 5'b00001;
  localparam logic [4:0] NPC_JAL  = 5'b00010;
  localparam logic [4:0] NPC_JALR = 5'b00100;

  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic [5:0] extop;
    logic [4:0] aluop;
    logic [4:0] npcop;
    logic [1:0] wdsel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  ctrl_t            dec;
  ctrl_t            ex_q, ex_d;
  logic             legal, use_rs1, use_rs2, hazard;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The external hazard-unit alias is accepted but not needed internally.
  logic unused_ex_memread;
  assign unused_ex_memread = ex_memread_i;

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec.rd  = instr_i[11:7];
    dec.rs1 = instr_i[19:15];
    dec.rs2 = instr_i[24:20];
    case (opcode)
      OP_LUI: begin
        legal        = 1'b1;
        dec.regwrite = 1'b1;
        dec.extop    = EXT_U;
        dec.aluop    = ALU_LUI;
        dec.alusrc   = 1'b1;
      end
      OP_IMM: begin
        legal        = 1'b1;
        use_rs1      = 1'b1;
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.extop    = EXT_I;
        case (funct3)
          3'b000:  dec.aluop = ALU_ADD;
          3'b010:  dec.aluop = ALU_SLT;
          3'b011:  dec.aluop = ALU_SLTU;
          3'b100:  dec.aluop = ALU_XOR;
          3'b110:  dec.aluop = ALU_OR;
          3'b111:  dec.aluop = ALU_AND;
          3'b001: begin
            dec.extop = EXT_SH;
            dec.aluop = ALU_SLL;
            legal     = (funct7 == 7'b0000000);
          end
          default: begin
            dec.extop = EXT_SH;
            dec.aluop = funct7[5] ? ALU_SRA : ALU_SRL;
            legal     = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
        endcase
      end
      OP_REG: begin
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.regwrite = 1'b1;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec.aluop = ALU_ADD;
            3'b001:  dec.aluop = ALU_SLL;
            3'b010:  dec.aluop = ALU_SLT;
            3'b011:  dec.aluop = ALU_SLTU;
            3'b100:  dec.aluop = ALU_XOR;
            3'b101:  dec.aluop = ALU_SRL;
            3'b110:  dec.aluop = ALU_OR;
            default: dec.aluop = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          legal     = (funct3 == 3'b000) || (funct3 == 3'b101);
          dec.aluop = (funct3 == 3'b000) ? ALU_SUB : ALU_SRA;
        end else if ((funct7 == 7'b0000001) && (EN_M != 0)) begin
          // RV32M codes are contiguous from mul in funct3 order.
          legal     = 1'b1;
          dec.aluop = ALU_MUL + {2'b00, funct3};
        end
      end
      OP_LOAD: begin
        legal        = (funct3 == 3'b010);
        use_rs1      = 1'b1;
        dec.regwrite = 1'b1;
        dec.memread  = 1'b1;
        dec.extop    = EXT_I;
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.wdsel    = WD_MEM;
      end
      OP_STORE: begin
        legal        = (funct3 == 3'b010);
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        dec.memwrite = 1'b1;
        dec.extop    = EXT_S;
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
      end
      OP_BRANCH: begin
        legal     = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        dec.extop = EXT_B;
        dec.npcop = NPC_BR;
        case (funct3)
          3'b000:  dec.aluop = ALU_SUB;
          3'b001:  dec.aluop = ALU_BNE;
          3'b100:  dec.aluop = ALU_BLT;
          3'b101:  dec.aluop = ALU_BGE;
          3'b110:  dec.aluop = ALU_BLTU;
          3'b111:  dec.aluop = ALU_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OP_JAL: begin
        legal        = 1'b1;
        dec.regwrite = 1'b1;
        dec.extop    = EXT_J;
        dec.npcop    = NPC_JAL;
        dec.wdsel    = WD_PC4;
      end
      OP_JALR: begin
        legal        = (funct3 == 3'b000);
        use_rs1      = 1'b1;
        dec.regwrite = 1'b1;
        dec.extop    = EXT_I;
        dec.aluop    = ALU_ADD;
        dec.alusrc   = 1'b1;
        dec.npcop    = NPC_JALR;
        dec.wdsel    = WD_PC4;
      end
      default: ;
    endcase
    // Illegal instructions keep their register indices but no control or source use.
    if (!legal) begin
      dec.regwrite = 1'b0;
      dec.memwrite = 1'b0;
      dec.memread  = 1'b0;
      dec.alusrc   = 1'b0;
      dec.extop    = '0;
      dec.aluop    = '0;
      dec.npcop    = '0;
      dec.wdsel    = '0;
      use_rs1      = 1'b0;
      use_rs2      = 1'b0;
    end
    dec.illegal = ~legal;
    dec.valid   = 1'b1;
  end

  assign hazard = id_valid_i & ~flush_i & ex_q.valid & ex_q.memread & (ex_q.rd != 5'd0) &
                  ((use_rs1 & (dec.rs1 == ex_q.rd)) | (use_rs2 & (dec.rs2 == ex_q.rd)));
  assign stall_o = (EN_HAZARD != 0) & hazard;

  always_comb begin
    ex_d = '0;
    if (id_valid_i && !flush_i && !stall_o) begin
      ex_d = dec;
    end
    cnt_d = cnt_q;
    if (stall_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_regwrite_o = ex_q.regwrite;
  assign ex_memwrite_o = ex_q.memwrite;
  assign ex_memread_o  = ex_q.memread;
  assign ex_alusrc_o   = ex_q.alusrc;
  assign ex_extop_o    = ex_q.extop;
  assign ex_aluop_o    = ex_q.aluop;
  assign ex_npcop_o    = ex_q.npcop;
  assign ex_wdsel_o    = ex_q.wdsel;
  assign ex_rd_o       = ex_q.rd;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_illegal_o  = ex_q.illegal;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// Bench for id_ex_ctrl_pipe: three parameter variants driven in parallel, checked every cycle
// against an instruction-class reference model, plus directed load-use and saturation scenarios.
module tb_id_ex_ctrl_pipe;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       alusrc;
    logic [5:0] extop;
    logic [4:0] aluop;
    logic [4:0] npcop;
    logic [1:0] wdsel;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } exp_t;

  typedef enum logic [3:0] {K_LUI, K_R, K_I, K_SH, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL} kind_t;
  typedef struct packed {
    kind_t      kind;
    logic [4:0] alu;
  } cls_t;

  logic        clk = 1'b0;
  logic        rstn, id_valid_i, flush_i, ex_memread_i;
  logic [31:0] instr_i;
  always #5 clk = ~clk;

  logic [2:0]       stall_w;
  logic [2:0][38:0] obs_w;
  logic [2:0][15:0] cnt_w;

  // Instance 0: no RV32M, hazard on, 16-bit counter; 1: RV32M, 2-bit counter; 2: RV32M, no hazard.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int P_EN_M  = (gi == 0) ? 0 : 1;
    localparam int P_EN_HZ = (gi == 2) ? 0 : 1;
    localparam int P_CNT_W = (gi == 1) ? 2 : 16;
    logic               v, rw, mw, mr, as, ill;
    logic [5:0]         ext;
    logic [4:0]         alu, npc, rd, rs1, rs2;
    logic [1:0]         wd;
    logic [P_CNT_W-1:0] cnt;
    id_ex_ctrl_pipe #(.EN_M(P_EN_M), .EN_HAZARD(P_EN_HZ), .CNT_W(P_CNT_W)) u_dut (
      .clk(clk), .rstn(rstn), .instr_i(instr_i), .id_valid_i(id_valid_i), .flush_i(flush_i),
      .ex_memread_i(ex_memread_i), .stall_o(stall_w[gi]), .ex_valid_o(v), .ex_regwrite_o(rw),
      .ex_memwrite_o(mw), .ex_memread_o(mr), .ex_alusrc_o(as), .ex_extop_o(ext),
      .ex_aluop_o(alu), .ex_npcop_o(npc), .ex_wdsel_o(wd), .ex_rd_o(rd), .ex_rs1_o(rs1),
      .ex_rs2_o(rs2), .ex_illegal_o(ill), .stall_cnt_o(cnt)
    );
    assign obs_w[gi] = {v, rw, mw, mr, as, ext, alu, npc, wd, rd, rs1, rs2, ill};
    assign cnt_w[gi] = 16'(cnt);
  end

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_en_m [3] = '{1'b0, 1'b1, 1'b1};
  bit          m_en_hz[3] = '{1'b1, 1'b1, 1'b0};
  logic [15:0] m_cmax [3] = '{16'hFFFF, 16'd3, 16'hFFFF};
  exp_t        mst    [3];
  logic [15:0] mcnt   [3];
  bit          mstall [3];

  // ALU codes by funct3 for each instruction family.
  logic [4:0] r_alu [8] = '{5'd3, 5'd15, 5'd10, 5'd11, 5'd12, 5'd16, 5'd13, 5'd14};
  logic [4:0] br_alu[8] = '{5'd4, 5'd5, 5'd0, 5'd0, 5'd6, 5'd7, 5'd8, 5'd9};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic cls_t classify(input logic [31:0] ins, input bit em);
    cls_t       c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    c.kind = K_ILL; c.alu = 5'd0;
    if (op == 7'h37) begin c.kind = K_LUI; c.alu = 5'd1; end
    else if (op == 7'h6F) c.kind = K_JAL;
    else if (op == 7'h67 && f3 == 3'd0) begin c.kind = K_JALR; c.alu = 5'd3; end
    else if (op == 7'h03 && f3 == 3'd2) begin c.kind = K_LW; c.alu = 5'd3; end
    else if (op == 7'h23 && f3 == 3'd2) begin c.kind = K_SW; c.alu = 5'd3; end
    else if (op == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin c.kind = K_BR; c.alu = br_alu[f3]; end
    else if (op == 7'h13) begin
      if (f3 == 3'd1 && f7 == 7'h00) begin c.kind = K_SH; c.alu = 5'd15; end
      else if (f3 == 3'd5 && f7 == 7'h00) begin c.kind = K_SH; c.alu = 5'd16; end
      else if (f3 == 3'd5 && f7 == 7'h20) begin c.kind = K_SH; c.alu = 5'd17; end
      else if (f3 != 3'd1 && f3 != 3'd5) begin c.kind = K_I; c.alu = r_alu[f3]; end
    end else if (op == 7'h33) begin
      if (f7 == 7'h00) begin c.kind = K_R; c.alu = r_alu[f3]; end
      else if (f7 == 7'h20 && f3 == 3'd0) begin c.kind = K_R; c.alu = 5'd4; end
      else if (f7 == 7'h20 && f3 == 3'd5) begin c.kind = K_R; c.alu = 5'd17; end
      else if (f7 == 7'h01 && em) begin c.kind = K_R; c.alu = 5'd18 + 5'(f3); end
    end
    return c;
  endfunction

  function automatic exp_t bundle(input cls_t c, input logic [31:0] ins);
    exp_t e;
    e = '0; e.valid = 1'b1;
    e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.aluop = c.alu;
    case (c.kind)
      K_LUI:  begin e.regwrite = 1; e.extop = 6'b000010; e.alusrc = 1; end
      K_R:    e.regwrite = 1;
      K_I:    begin e.regwrite = 1; e.extop = 6'b010000; e.alusrc = 1; end
      K_SH:   begin e.regwrite = 1; e.extop = 6'b100000; e.alusrc = 1; end
      K_LW:   begin e.regwrite = 1; e.memread = 1; e.extop = 6'b010000; e.alusrc = 1; e.wdsel = 2'b01; end
      K_SW:   begin e.memwrite = 1; e.extop = 6'b001000; e.alusrc = 1; end
      K_BR:   begin e.extop = 6'b000100; e.npcop = 5'b00001; end
      K_JAL:  begin e.regwrite = 1; e.extop = 6'b000001; e.npcop = 5'b00010; e.wdsel = 2'b10; end
      K_JALR: begin e.regwrite = 1; e.extop = 6'b010000; e.alusrc = 1; e.npcop = 5'b00100; e.wdsel = 2'b10; end
      default: e.illegal = 1;
    endcase
    return e;
  endfunction

  function automatic bit uses_rs1(input kind_t k);
    return !(k == K_LUI || k == K_JAL || k == K_ILL);
  endfunction

  function automatic bit uses_rs2(input kind_t k);
    return (k == K_R || k == K_SW || k == K_BR);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, f7r, f7i;
    logic [31:0] r;
    rd  = 5'($urandom_range(0, 3));
    rs1 = 5'($urandom_range(0, 3));
    rs2 = 5'($urandom_range(0, 3));
    f3  = 3'($urandom);
    f7  = 7'($urandom);
    f7r = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    f7i = (f3 == 3'd1 || f3 == 3'd5) ? ((f3 == 3'd5) ? f7r : 7'h00) : f7;
    case ($urandom_range(0, 11))
      0, 10:   r = {f7, rs2, rs1, 3'b010, rd, 7'h03};
      1:       r = {f7, rs2, rs1, 3'b010, rd, 7'h23};
      2:       r = {f7r, rs2, rs1, f3, rd, 7'h33};
      3:       r = {f7i, rs2, rs1, f3, rd, 7'h13};
      4:       r = {f7, rs2, rs1, f3, rd, 7'h63};
      5:       r = {f7, rs2, rs1, f3, rd, 7'h6F};
      6:       r = {f7, rs2, rs1, 3'b000, rd, 7'h67};
      7:       r = {f7, rs2, rs1, f3, rd, 7'h37};
      8:       r = {7'h01, rs2, rs1, f3, rd, 7'h33};
      9:       r = $urandom;
      default: r = {f7, rs2, rs1, f3, rd, 7'($urandom)};
    endcase
    return r;
  endfunction

  // One clock: drive, check comb stall and registered state, then advance the model.
  task automatic cycle(input logic [31:0] ins, input logic v, input logic fl, input logic rn,
                       input int exp_st0, output bit st0);
    cls_t c;
    exp_t nb[3];
    instr_i = ins; id_valid_i = v; flush_i = fl; rstn = rn;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      c = classify(ins, m_en_m[k]);
      nb[k] = bundle(c, ins);
      mstall[k] = m_en_hz[k] && v && !fl && mst[k].valid && mst[k].memread && (mst[k].rd != 5'd0) &&
                  ((uses_rs1(c.kind) && ins[19:15] == mst[k].rd) ||
                   (uses_rs2(c.kind) && ins[24:20] == mst[k].rd));
      check_eq($sformatf("stall[%0d]", k), 64'(stall_w[k]), 64'(mstall[k]));
      check_eq($sformatf("ex_bundle[%0d]", k), 64'(obs_w[k]), 64'(mst[k]));
      check_eq($sformatf("stall_cnt[%0d]", k), 64'(cnt_w[k]), 64'(mcnt[k]));
    end
    if (exp_st0 >= 0) check_eq("directed_stall", 64'(stall_w[0]), 64'(exp_st0));
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!rn) begin
        mst[k]  = '0;
        mcnt[k] = '0;
      end else begin
        if (mstall[k] && mcnt[k] != m_cmax[k]) mcnt[k] = mcnt[k] + 16'd1;
        mst[k] = (fl || mstall[k] || !v) ? exp_t'('0) : nb[k];
      end
    end
    #1;
    st0 = mstall[0];
  endtask

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] ADD_3_12 = 32'h002081B3;
  localparam logic [31:0] LW_5     = 32'h0000A283;
  localparam logic [31:0] ADD_6_51 = 32'h00128333;
  localparam logic [31:0] LW_0     = 32'h0000A003;
  localparam logic [31:0] ADD_6_01 = 32'h00100333;
  localparam logic [31:0] LW_6_5   = 32'h0002A303;
  localparam logic [31:0] LW_7_6   = 32'h00032383;
  localparam logic [31:0] MUL_1_23 = 32'h023100B3;

  initial begin
    bit          st;
    exp_t        o0, o1;
    logic [31:0] ins;
    logic        v, fl, rn;
    rstn = 1'b0; id_valid_i = 1'b1; flush_i = 1'b0; ex_memread_i = 1'b0; instr_i = $urandom;
    for (int k = 0; k < 3; k++) begin mst[k] = '0; mcnt[k] = '0; end
    @(posedge clk); #1;

    // Reset holds everything at zero regardless of instr_i.
    repeat (2) cycle($urandom, 1'b1, 1'b0, 1'b0, 0, st);
    check_eq("reset_bundle", 64'(obs_w[0]), 64'd0);
    check_eq("reset_cnt", 64'(cnt_w[0]), 64'd0);

    // add x3,x1,x2
    cycle(ADD_3_12, 1'b1, 1'b0, 1'b1, 0, st);
    o0 = obs_w[0];
    check_eq("add_aluop", 64'(o0.aluop), 64'(5'b00011));
    check_eq("add_regwrite", 64'(o0.regwrite), 64'd1);
    check_eq("add_rd", 64'(o0.rd), 64'd3);
    check_eq("add_wdsel", 64'(o0.wdsel), 64'd0);

    // Load-use: one stall, EX bubble, dependent add enters next cycle.
    cycle(NOP, 1'b1, 1'b0, 1'b0, -1, st);
    cycle(LW_5, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(ADD_6_51, 1'b1, 1'b0, 1'b1, 1, st);
    o0 = obs_w[0];
    check_eq("lu_bubble_valid", 64'(o0.valid), 64'd0);
    cycle(ADD_6_51, 1'b1, 1'b0, 1'b1, 0, st);
    o0 = obs_w[0];
    check_eq("lu_add_rd", 64'(o0.rd), 64'd6);
    check_eq("lu_add_aluop", 64'(o0.aluop), 64'(5'b00011));
    check_eq("lu_cnt", 64'(cnt_w[0]), 64'd1);

    // x0 destination never stalls.
    cycle(NOP, 1'b1, 1'b0, 1'b0, -1, st);
    cycle(LW_0, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(ADD_6_01, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(NOP, 1'b1, 1'b0, 1'b1, 0, st);

    // Flush in the hazard cycle wins.
    cycle(NOP, 1'b1, 1'b0, 1'b0, -1, st);
    cycle(LW_5, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(ADD_6_51, 1'b1, 1'b1, 1'b1, 0, st);
    o0 = obs_w[0];
    check_eq("flush_bubble_valid", 64'(o0.valid), 64'd0);
    check_eq("flush_cnt", 64'(cnt_w[0]), 64'd0);

    // mul: illegal without RV32M, decoded with it.
    cycle(MUL_1_23, 1'b1, 1'b0, 1'b1, 0, st);
    o0 = obs_w[0]; o1 = obs_w[1];
    check_eq("mul_illegal_m0", 64'(o0.illegal), 64'd1);
    check_eq("mul_valid_m0", 64'(o0.valid), 64'd1);
    check_eq("mul_regwrite_m0", 64'(o0.regwrite), 64'd0);
    check_eq("mul_aluop_m1", 64'(o1.aluop), 64'(5'b10010));
    check_eq("mul_regwrite_m1", 64'(o1.regwrite), 64'd1);

    // Reset during a stall cycle.
    cycle(NOP, 1'b1, 1'b0, 1'b0, -1, st);
    cycle(LW_5, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(ADD_6_51, 1'b1, 1'b0, 1'b0, 1, st);
    cycle(ADD_6_51, 1'b1, 1'b0, 1'b1, 0, st);
    check_eq("rst_midstall_cnt", 64'(cnt_w[0]), 64'd0);

    // Back-to-back dependent loads: one stall each.
    cycle(LW_5, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(LW_6_5, 1'b1, 1'b0, 1'b1, 1, st);
    cycle(LW_6_5, 1'b1, 1'b0, 1'b1, 0, st);
    cycle(LW_7_6, 1'b1, 1'b0, 1'b1, 1, st);
    cycle(LW_7_6, 1'b1, 1'b0, 1'b1, 0, st);

    // Five stalls: 2-bit counter saturates at 3.
    cycle(NOP, 1'b1, 1'b0, 1'b0, -1, st);
    repeat (5) begin
      cycle(LW_5, 1'b1, 1'b0, 1'b1, 0, st);
      cycle(ADD_6_51, 1'b1, 1'b0, 1'b1, 1, st);
      cycle(ADD_6_51, 1'b1, 1'b0, 1'b1, 0, st);
    end
    check_eq("sat_cnt_w2", 64'(cnt_w[1]), 64'd3);
    check_eq("sat_cnt_w16", 64'(cnt_w[0]), 64'd5);
    check_eq("nohazard_cnt", 64'(cnt_w[2]), 64'd0);

    // Random traffic; the instruction is held in ID while the model predicts a stall.
    ins = rand_instr();
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 49) != 0);
      cycle(ins, v, fl, rn, -1, st);
      if (!st) ins = rand_instr();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
